// File: rtl/nco_pkg.sv
// Shared constants and types for the nco host-side interface.
package nco_pkg;

    localparam int NCO_PIPE_DEPTH = 9;
    localparam int FCW_W          = 20;
    localparam int DW             = 12;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} host_state_t;

    typedef struct packed {
        logic          selxy;
        logic          selsign;
        logic [DW-1:0] dout;
    } sample_t;

endpackage

// File: rtl/nco_host_fifo.sv
// First-word-fall-through sample FIFO. A push on a full FIFO is dropped
// and reported unless a pop in the same cycle frees a slot.
module nco_host_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 14
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic         empty,
    output logic         full,
    output logic         drop,
    output logic [W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_pop;
    logic         do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full, the write lands on the slot being popped this same cycle.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/nco_host_if.sv
// Host-side driver for the nco pins: nibble FCW loader, run/drain sequencer
// and sample capture FIFO. Optional selection rotation: NCO_HOST_IF_ROTATE_EN.
module nco_host_if #(
    parameter int FIFO_DEPTH = 8,
    parameter int FCW_W      = 20,
    parameter int DW         = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [3:0]       cfg_data,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    input  logic [1:0]       sel_cfg,
    output logic             busy,
    output logic             ovf,
    output logic             nco_en,
    output logic [FCW_W-1:0] nco_fcw,
    output logic             nco_selxy,
    output logic             nco_selsign,
    input  logic             nco_vld,
    input  logic [DW-1:0]    nco_dout,
    output logic             m_valid,
    output logic [DW+1:0]    m_data,
    input  logic             m_ready
);

    import nco_pkg::*;

    // state | meaning
    // IDLE  | config accepted, waiting for first nibble or start
    // LOAD  | collecting remaining FCW nibbles
    // RUN   | nco enabled, capturing samples
    // DRAIN | nco disabled, flushing samples still in the nco pipeline

    localparam int NIBBLES = FCW_W / 4;
    localparam int NW      = $clog2(NIBBLES + 1);
    localparam int DRW     = $clog2(NCO_PIPE_DEPTH);

    host_state_t      state;
    host_state_t      state_nxt;
    logic [FCW_W-5:0] fcw_sh;
    logic [FCW_W-1:0] fcw_shifted;
    logic [NW-1:0]    nib_left;
    logic [DRW-1:0]   drain_left;
    logic             nib_acc;
    logic             go;
    logic             capture;
    logic             fifo_pop;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_drop;
    logic [1:0]       sel;
    logic [1:0]       tag;
    logic [DW+1:0]    push_data;

    assign go          = start && !stop;
    assign nib_acc     = cfg_valid && cfg_ready;
    assign fcw_shifted = {fcw_sh, cfg_data};
    assign capture     = nco_vld && (state == RUN || state == DRAIN);
    assign sel         = {nco_selxy, nco_selsign};
    assign fifo_pop    = m_valid && m_ready;
    assign push_data   = {tag, nco_dout};
    assign m_valid     = !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (go) state_nxt = RUN;
                     else if (nib_acc) state_nxt = LOAD;
            LOAD:    if (nib_acc && nib_left == NW'(1)) state_nxt = IDLE;
            RUN:     if (stop) state_nxt = DRAIN;
            DRAIN:   if (drain_left == '0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = 1'b0;
        busy      = 1'b1;
        nco_en    = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = !rst;
                busy      = 1'b0;
            end
            LOAD:    cfg_ready = !rst;
            RUN:     nco_en = 1'b1;
            default: ;
        endcase
    end

    // nco_fcw only changes on the final nibble so the nco never sees a partial word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcw_sh   <= '0;
            nib_left <= '0;
            nco_fcw  <= '0;
        end else if (nib_acc) begin
            fcw_sh <= fcw_shifted[FCW_W-5:0];
            if (state == IDLE && !go) begin
                nib_left <= NW'(NIBBLES - 1);
            end else if (state == LOAD) begin
                nib_left <= nib_left - 1'b1;
                if (nib_left == NW'(1)) nco_fcw <= fcw_shifted;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drain_left <= '0;
        end else if (state == RUN && stop) begin
            drain_left <= DRW'(NCO_PIPE_DEPTH - 1);
        end else if (state == DRAIN && drain_left != '0) begin
            drain_left <= drain_left - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == IDLE && go) begin
            ovf <= 1'b0;
        end else if (fifo_drop) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {nco_selxy, nco_selsign} <= 2'b00;
        end else if (state == IDLE && go) begin
            {nco_selxy, nco_selsign} <= sel_cfg;
`ifdef NCO_HOST_IF_ROTATE_EN
        end else if (state == RUN && capture && (!fifo_full || fifo_pop)) begin
            {nco_selxy, nco_selsign} <= sel + 2'd1;
`endif
        end
    end

`ifdef NCO_HOST_IF_ROTATE_EN
    // Tag each sample with the selection that was live when it entered the nco pipeline.
    logic [1:0] sel_dly [NCO_PIPE_DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCO_PIPE_DEPTH; i++) sel_dly[i] <= 2'b00;
        end else begin
            sel_dly[0] <= sel;
            for (int i = 1; i < NCO_PIPE_DEPTH; i++) sel_dly[i] <= sel_dly[i-1];
        end
    end

    assign tag = sel_dly[NCO_PIPE_DEPTH-1];
`else
    assign tag = sel;
`endif

    nco_host_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DW + 2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (capture),
        .push_data (push_data),
        .pop       (fifo_pop),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .drop      (fifo_drop),
        .head      (m_data)
    );

endmodule

// File: tb/tb_nco_host_if.sv
// Randomized bench for nco_host_if against a queue-based behavioural model,
// plus directed load, stream, overflow, drain and async-reset scenarios.
module tb_nco_host_if;

    import nco_pkg::*;

    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [3:0]    cfg_data = '0;
    logic          cfg_ready;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    sel_cfg = '0;
    logic          busy;
    logic          ovf;
    logic          nco_en;
    logic [FCW_W-1:0] nco_fcw;
    logic          nco_selxy;
    logic          nco_selsign;
    logic          nco_vld = 1'b0;
    logic [DW-1:0] nco_dout = '0;
    logic          m_valid;
    logic [DW+1:0] m_data;
    logic          m_ready = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model
    bit             md_run;
    int             md_drain;
    int             md_nib;
    logic [FCW_W-1:0] md_acc;
    logic [FCW_W-1:0] md_fcw;
    logic [1:0]     md_sel;
    bit             md_ovf;
    logic [DW+1:0]  q[$];
    logic [1:0]     hist[$];

    nco_host_if #(.FIFO_DEPTH(DEPTH), .FCW_W(FCW_W), .DW(DW)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .start(start), .stop(stop), .sel_cfg(sel_cfg),
        .busy(busy), .ovf(ovf), .nco_en(nco_en), .nco_fcw(nco_fcw),
        .nco_selxy(nco_selxy), .nco_selsign(nco_selsign), .nco_vld(nco_vld),
        .nco_dout(nco_dout), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_reset();
        md_run = 0; md_drain = 0; md_nib = 0;
        md_acc = '0; md_fcw = '0; md_sel = 2'b00; md_ovf = 0;
        q.delete();
        hist.delete();
        for (int i = 0; i < NCO_PIPE_DEPTH; i++) hist.push_back(2'b00);
    endtask

    function automatic bit model_idle();
        return !md_run && md_drain == 0 && md_nib == 0;
    endfunction

    task automatic compare_all();
        check_val("busy", busy, !model_idle());
        check_val("cfg_ready", cfg_ready, !md_run && md_drain == 0);
        check_val("nco_en", nco_en, md_run);
        check_val("nco_fcw", nco_fcw, md_fcw);
        check_val("sel", {nco_selxy, nco_selsign}, md_sel);
        check_val("ovf", ovf, md_ovf);
        check_val("m_valid", m_valid, q.size() > 0);
        check_val("m_data", m_data, (q.size() > 0) ? q[0] : '0);
    endtask

    task automatic model_update();
        bit idle, pop, cap;
        logic [1:0] tag, old_sel;
        idle    = model_idle();
        old_sel = md_sel;
        pop     = (q.size() > 0) && m_ready;
        cap     = nco_vld && (md_run || md_drain > 0);
`ifdef NCO_HOST_IF_ROTATE_EN
        tag = hist[NCO_PIPE_DEPTH-1];
`else
        tag = md_sel;
`endif
        if (pop) void'(q.pop_front());
        if (cap) begin
            if (q.size() < DEPTH) begin
                q.push_back({tag, nco_dout});
`ifdef NCO_HOST_IF_ROTATE_EN
                if (md_run) md_sel = md_sel + 2'd1;
`endif
            end else begin
                md_ovf = 1;
            end
        end
        if (idle) begin
            if (start && !stop) begin
                md_run = 1; md_sel = sel_cfg; md_ovf = 0;
            end else if (cfg_valid) begin
                md_acc = (md_acc << 4) | FCW_W'(cfg_data);
                md_nib = 1;
            end
        end else if (md_nib > 0) begin
            if (cfg_valid) begin
                md_acc = (md_acc << 4) | FCW_W'(cfg_data);
                md_nib++;
                if (md_nib == FCW_W / 4) begin
                    md_fcw = md_acc;
                    md_nib = 0;
                end
            end
        end else if (md_run) begin
            if (stop) begin
                md_run = 0;
                md_drain = NCO_PIPE_DEPTH;
            end
        end else begin
            md_drain--;
        end
        hist.push_front(old_sel);
        void'(hist.pop_back());
    endtask

    task automatic step();
        @(negedge clk);
        compare_all();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        cfg_valid = 0; start = 0; stop = 0; nco_vld = 0;
    endtask

    task automatic go_idle();
        quiet();
        for (int i = 0; i < 40 && !model_idle(); i++) begin
            cfg_valid = (md_nib > 0);
            cfg_data  = 4'($urandom);
            stop      = md_run;
            step();
        end
        quiet();
        check_val("reach_idle", busy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_cfg_ready"}, cfg_ready, 0);
        check_val({tag, "_busy"}, busy, 0);
        check_val({tag, "_ovf"}, ovf, 0);
        check_val({tag, "_nco_en"}, nco_en, 0);
        check_val({tag, "_nco_fcw"}, nco_fcw, 0);
        check_val({tag, "_sel"}, {nco_selxy, nco_selsign}, 0);
        check_val({tag, "_m_valid"}, m_valid, 0);
        check_val({tag, "_m_data"}, m_data, 0);
    endtask

    initial begin
        logic [DW-1:0] vals [10];
        logic [3:0]    nib  [5];

        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;

        // FCW load with random gaps between nibbles
        for (int i = 0; i < 5; i++) nib[i] = 4'(i + 1);
        for (int i = 0; i < 5; i++) begin
            while ($urandom_range(0, 2) == 0) begin
                cfg_valid = 0; step();
            end
            cfg_valid = 1; cfg_data = nib[i]; step();
            if (i == 3) check_val("fcw_partial", nco_fcw, 0);
        end
        cfg_valid = 0;
        check_val("fcw_load", nco_fcw, 20'h12345);
        for (int i = 0; i < 5; i++) begin
            cfg_valid = 1; cfg_data = 4'($urandom); step();
        end
        quiet();
        step();

        // stream with sel 10
        m_ready = 1; sel_cfg = 2'b10; start = 1; step(); start = 0;
        for (int i = 0; i < 5; i++) begin
            nco_vld = 1; nco_dout = DW'(12'h100 + i); step();
`ifndef NCO_HOST_IF_ROTATE_EN
            check_val("stream_head", m_data, 14'h2100 + i);
`endif
            if (i == 0) check_val("first_latency", m_valid, 1);
        end
        nco_vld = 0;
        stop = 1; step(); stop = 0;
        check_val("stop_en", nco_en, 0);
        for (int i = 0; i < NCO_PIPE_DEPTH; i++) begin
            nco_vld = $urandom_range(0, 1); nco_dout = DW'($urandom); step();
            if (i == NCO_PIPE_DEPTH - 2) check_val("drain_busy", busy, 1);
        end
        nco_vld = 0;
        check_val("drain_done", busy, 0);
        for (int i = 0; i < 12; i++) step();

        // overflow
        m_ready = 0; start = 1; step(); start = 0;
        for (int i = 0; i < 10; i++) begin
            vals[i] = DW'($urandom);
            nco_vld = 1; nco_dout = vals[i]; step();
        end
        nco_vld = 0;
        check_val("ovf_set", ovf, 1);
        m_ready = 1;
        for (int i = 0; i < 8; i++) begin
            check_val("ovf_keep", m_data[DW-1:0], vals[i]);
            step();
        end
        check_val("ovf_empty", m_valid, 0);
        go_idle();
        start = 1; sel_cfg = 2'($urandom); step(); start = 0;
        check_val("ovf_clear", ovf, 0);

        // full FIFO with simultaneous push and pop
        m_ready = 0;
        for (int i = 0; i < 8; i++) begin
            nco_vld = 1; nco_dout = DW'($urandom); step();
        end
        m_ready = 1; nco_vld = 1; nco_dout = DW'($urandom); step();
        nco_vld = 0; m_ready = 0;
        check_val("full_pushpop_ovf", ovf, 0);
        check_val("full_pushpop_cnt", q.size(), 8);
        m_ready = 1;
        go_idle();
        for (int i = 0; i < 10; i++) step();

        // start and stop together from idle
        start = 1; stop = 1; step(); quiet();
        check_val("startstop_busy", busy, 0);
        check_val("startstop_en", nco_en, 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            cfg_valid = ($urandom_range(0, 9) < 3);
            cfg_data  = 4'($urandom);
            start     = ($urandom_range(0, 19) == 0);
            stop      = ($urandom_range(0, 29) == 0);
            sel_cfg   = 2'($urandom);
            nco_vld   = $urandom_range(0, 1);
            nco_dout  = DW'($urandom);
            m_ready   = ($urandom_range(0, 9) < 4);
            step();
        end

        // async reset mid-run with samples queued
        go_idle();
        m_ready = 0; sel_cfg = 2'b11; start = 1; step(); start = 0;
        for (int i = 0; i < 3; i++) begin
            nco_vld = 1; nco_dout = DW'($urandom); step();
        end
        nco_vld = 0;
        check_val("pre_reset_valid", m_valid, 1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_host_if.md
Name: nco_host_if

Overview:
- Host-side counterpart to the nco core's pin interface.
- Assembles a 20-bit FCW from a 4-bit nibble config bus, then drives En/FCW/selXY/selSign into the nco.
- Captures the nco's Vld/Dout[11:0] output stream into a small FIFO with a ready/valid read port.
- Sits on the board/FPGA side of the split-IO link and replaces hand-driven pins in bring-up and verification.

Parameters:
- FIFO_DEPTH, 8, sample FIFO entries; power of two, at least 2.
- FCW_W, 20, frequency control word width; a multiple of 4.
- DW, 12, nco Dout width.

Ports:
- clk  in  1  single clock, shared with the nco.
- rst  in  1  asynchronous, active-high reset.
- cfg_valid  in  1  nibble valid.
- cfg_data  in  4  FCW nibble, MSB nibble first.
- cfg_ready  out  1  nibble accepted when valid&ready.
- start  in  1  pulse; begin streaming.
- stop  in  1  pulse; end streaming.
- sel_cfg  in  2  {selXY, selSign}, sampled at start.
- busy  out  1  FSM not in IDLE.
- ovf  out  1  sticky; a sample was dropped on a full FIFO.
- nco_en  out  1  to nco En.
- nco_fcw  out  FCW_W  to nco FCW.
- nco_selxy  out  1  to nco selXY.
- nco_selsign  out  1  to nco selSign.
- nco_vld  in  1  from nco Vld.
- nco_dout  in  DW  from nco Dout.
- m_valid  out  1  sample available.
- m_data  out  DW+2  {selXY, selSign, Dout}.
- m_ready  in  1  consumer accepts.

Behaviour:
- Reset values (asynchronous, all outputs):
  - Zero: cfg_ready, busy, ovf, nco_en, nco_fcw, nco_selxy, nco_selsign, m_valid, m_data.
  - FIFO empty; FSM in IDLE.
- FSM states:
  - IDLE: cfg_ready=1. An accepted nibble goes to LOAD with count=1.
  - LOAD: cfg_ready=1. Shift register: fcw_sh <= {fcw_sh[FCW_W-5:0], cfg_data}. After FCW_W/4 accepted nibbles (5 by default), nco_fcw <= fcw_sh and the FSM returns to IDLE. No partial update of nco_fcw is ever visible.
  - start in IDLE: latch sel_cfg onto nco_selxy/nco_selsign, go to RUN, nco_en=1 from the next cycle. Also clear ovf.
  - start in LOAD: ignored.
  - RUN: cfg_ready=0. Every cycle with nco_vld=1 pushes {nco_selxy, nco_selsign, nco_dout}; pushes are unconditional because the nco has no backpressure. If the FIFO is full at push time, the sample is dropped, ovf<=1 and the FIFO contents are unchanged. stop goes to DRAIN with nco_en=0 the next cycle.
  - DRAIN: still captures nco_vld for 9 cycles (pipeline depth: accumulator plus 8 CORDIC stages) to flush in-flight samples, then returns to IDLE.
  - start and stop asserted in the same cycle: stop wins (stays/returns IDLE).
  - start in RUN/DRAIN: ignored.
  - stop in IDLE/LOAD: ignored.
- FIFO:
  - Synchronous FWFT.
  - m_valid = not empty; m_data = head entry, combinationally valid while m_valid.
  - A pop occurs on m_valid&m_ready.
  - Simultaneous push and pop when full: the pop frees a slot, so the push succeeds and no overflow is flagged.
  - Pointers are log2(FIFO_DEPTH)+1 bits; full/empty by MSB compare. Pointers wrap naturally.
- busy = (state != IDLE).
- FIFO reads continue in any state.
- Reset mid-RUN: nco_en drops immediately (async) and the FIFO is emptied.
- Latency: nco_vld to m_valid is 1 cycle when the FIFO was empty.

Optional Feature:
- Macro: NCO_HOST_IF_ROTATE_EN.
- Defined: in RUN, {nco_selxy, nco_selsign} advance 00→01→10→11→00 after every accepted capture. This interleaves all four output selections. The tag stored with each sample is the selection value driven 9 cycles earlier, via a 9-deep 2-bit delay line, so tags match pipeline latency.
- Undefined: the selection is static from start, the tag is the current register value, and no delay line exists.

Decomposition:
- Package nco_pkg:
  - Constants NCO_PIPE_DEPTH=9, FCW_W=20, DW=12.
  - typedef enum logic[1:0] {IDLE, LOAD, RUN, DRAIN} host_state_t.
  - typedef struct packed sample_t {selxy, selsign, dout}.
- One sub-module: nco_host_fifo, a parameterized FWFT FIFO with full/empty and push-on-full drop reporting.

Test Plan:
- Load: send nibbles 0x1,0x2,0x3,0x4,0x5 with cfg_ready high → nco_fcw=20'h12345 after the 5th nibble, unchanged before it.
- Stream: sel_cfg=2'b10, start; model drives nco_vld with dout 0x100..0x104 → m_data pops 0x2100..0x2104 in order; m_valid 1 cycle after the first nco_vld.
- Overflow: m_ready=0, FIFO_DEPTH=8, 10 vld samples → 8 stored (first 8 values), ovf=1. Next start clears ovf.
- Full push+pop: FIFO full, m_ready=1 and nco_vld=1 in the same cycle → occupancy stays 8, ovf stays 0.
- Stop/drain: stop during RUN → nco_en=0 next cycle; vld samples within the following 9 cycles are captured; busy falls after the 9th drain cycle. start+stop in the same cycle from IDLE → no transition.
- Async reset mid-RUN with 3 samples queued → all outputs 0 and m_valid=0 immediately, without a clock edge. With NCO_HOST_IF_ROTATE_EN, 4 consecutive samples carry tags 00,01,10,11 (once the delay line is filled).
